motor_ramp_drv: RTL and testbench

Multi-channel H-bridge motor driver with PWM generation, slew-rate-limited duty ramping, dead-time-protected direction reversal and active braking. It replaces the fixed two-motor PWM path. The top-level controller writes a per-channel target duty and direction. The block ramps each channel toward its target and drives the PWM pin and the IN pair for each bridge. All channels share one PWM period counter, so their edges stay phase-aligned.

---
 rtl/motor_ramp_drv.sv | 146 ++++++++++++++
 tb/tb_motor_ramp_drv.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_drv.sv
// rtl/motor_ramp_drv.sv - multi-channel H-bridge PWM driver with slew-limited duty, dead-time reversal and braking
module motor_ramp_drv #(
  parameter int CH       = 2,
  parameter int DUTY_W   = 10,
  parameter int CLK_HZ   = 100_000_000,
  parameter int PWM_HZ   = 25_000,
  parameter int RAMP_DIV = 100_000,
  parameter int STEP     = 4,
  parameter int DEAD_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH*DUTY_W-1:0] target_duty,
  input  logic [CH-1:0]        target_dir,
  input  logic [CH-1:0]        brake,
  output logic [CH-1:0]        pwm,
  output logic [CH-1:0]        in_a,
  output logic [CH-1:0]        in_b,
  output logic [CH*DUTY_W-1:0] cur_duty,
  output logic [CH-1:0]        settled
);

  localparam int PERIOD = CLK_HZ / PWM_HZ;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);

  typedef enum logic [1:0] {S_RUN, S_DECEL, S_DEAD, S_BRAKE} state_t;

  logic [CNT_W-1:0] cnt;
  logic [PRE_W-1:0] pre;
  logic             period_end;
  logic             tick;

  assign period_end = (cnt == CNT_W'(PERIOD - 1));
  assign tick       = (pre == PRE_W'(RAMP_DIV - 1));

  // One period counter and one prescaler shared by all channels keeps PWM edges phase-aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      pre <= '0;
    end else begin
      cnt <= period_end ? '0 : cnt + CNT_W'(1);
      pre <= tick ? '0 : pre + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t              state;
    logic                cur_dir;
    logic [DUTY_W-1:0]   duty;
    logic [DUTY_W-1:0]   tgt;
    logic [DEAD_W-1:0]   dead;
    logic [CNT_W-1:0]    thr;
    logic [31:0]         prod;
    logic                pwm_q, in_a_q, in_b_q, settled_q;

    assign tgt  = target_duty[i*DUTY_W +: DUTY_W];
    assign prod = 32'(PERIOD) * 32'(duty);

    assign pwm[i]                       = pwm_q;
    assign in_a[i]                      = in_a_q;
    assign in_b[i]                      = in_b_q;
    assign settled[i]                   = settled_q;
    assign cur_duty[i*DUTY_W +: DUTY_W] = duty;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state     <= S_RUN;
        cur_dir   <= 1'b1;
        duty      <= '0;
        dead      <= '0;
        thr       <= '0;
        pwm_q     <= 1'b0;
        in_a_q    <= 1'b0;
        in_b_q    <= 1'b0;
        settled_q <= 1'b0;
      end else begin
        // Threshold only moves at the period boundary so a running pulse is never cut short
        if (period_end)
          thr <= CNT_W'(prod >> DUTY_W);

        if (brake[i]) begin
          state <= S_BRAKE;
          duty  <= '0;
          dead  <= '0;
        end else begin
          case (state)
            S_RUN: begin
              if (target_dir[i] != cur_dir) begin
                state <= S_DECEL;
              end else if (tick) begin
                if (duty < tgt)
                  duty <= ((tgt - duty) > STEP_V) ? duty + STEP_V : tgt;
                else if (duty > tgt)
                  duty <= ((duty - tgt) > STEP_V) ? duty - STEP_V : tgt;
              end
            end
            S_DECEL: begin
              if (target_dir[i] == cur_dir) begin
                state <= S_RUN;
              end else if (duty == '0) begin
                state <= S_DEAD;
                dead  <= DEAD_W'(DEAD_CYC - 1);
              end else if (tick) begin
                duty <= (duty > STEP_V) ? duty - STEP_V : '0;
              end
            end
            S_DEAD: begin
              if (dead == '0) begin
                cur_dir <= target_dir[i];
                state   <= S_RUN;
              end else begin
                dead <= dead - DEAD_W'(1);
              end
            end
            default: begin
              cur_dir <= target_dir[i];
              state   <= S_RUN;
            end
          endcase
        end

        pwm_q <= ((state == S_RUN) || (state == S_DECEL)) && (cnt < thr);
        case (state)
          S_RUN, S_DECEL: begin
            in_a_q <= cur_dir;
            in_b_q <= !cur_dir;
          end
          S_DEAD: begin
            in_a_q <= 1'b0;
            in_b_q <= 1'b0;
          end
          default: begin
            in_a_q <= 1'b1;
            in_b_q <= 1'b1;
          end
        endcase
        settled_q <= (state == S_RUN) && (cur_dir == target_dir[i]) && (duty == tgt);
      end
    end
  end

endmodule

// File: tb/tb_motor_ramp_drv.sv
// tb/tb_motor_ramp_drv.sv - scoreboard bench for motor_ramp_drv
module tb_motor_ramp_drv;
  localparam int CH = 2;
  localparam int DW = 10;

  typedef enum int {K_DUTY, K_PWM, K_INAB, K_SET, K_PCNT, K_CLR, K_ALL0} kind_t;
  typedef struct {
    string name;
    int    ch;
    kind_t kind;
    int    exp;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CH*DW-1:0] target_duty;
  logic [CH-1:0]    target_dir;
  logic [CH-1:0]    brake;
  logic [CH-1:0]    pwm, in_a, in_b, settled;
  logic [CH*DW-1:0] cur_duty;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   pwm_hi[CH];

  motor_ramp_drv #(
    .CH(CH), .DUTY_W(DW), .CLK_HZ(100_000_000), .PWM_HZ(25_000),
    .RAMP_DIV(10), .STEP(8), .DEAD_CYC(50)
  ) dut (
    .clk(clk), .rst(rst), .target_duty(target_duty), .target_dir(target_dir),
    .brake(brake), .pwm(pwm), .in_a(in_a), .in_b(in_b),
    .cur_duty(cur_duty), .settled(settled)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) cyc = 0;
      else cyc = cyc + 1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic void push(input string n, input int ch, input kind_t k, input int e);
    exp_t x;
    x.name = n;
    x.ch   = ch;
    x.kind = k;
    x.exp  = e;
    sb.push_back(x);
  endfunction

  initial begin
    exp_t e;
    int   act;
    bit   do_chk;
    for (int c = 0; c < CH; c++) pwm_hi[c] = 0;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        do_chk = 1'b1;
        act = 0;
        case (e.kind)
          K_DUTY: act = int'(cur_duty[e.ch*DW +: DW]);
          K_PWM:  act = int'(pwm[e.ch]);
          K_INAB: act = int'({in_a[e.ch], in_b[e.ch]});
          K_SET:  act = int'(settled[e.ch]);
          K_PCNT: begin
            act = pwm_hi[e.ch];
            pwm_hi[e.ch] = 0;
          end
          K_CLR: begin
            pwm_hi[e.ch] = 0;
            do_chk = 1'b0;
          end
          default: act = int'({pwm, in_a, in_b, settled}) | int'(cur_duty);
        endcase
        if (do_chk) begin
          n_chk++;
          if (act == e.exp) n_pass++;
          else $display("FAIL %s ch%0d at cyc %0d: got %0d expected %0d", e.name, e.ch, cyc, act, e.exp);
        end
      end
      for (int c = 0; c < CH; c++) pwm_hi[c] += int'(pwm[c]);
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    target_duty = {10'd13, 10'd512};
    target_dir  = 2'b11;
    brake       = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    push("reset_outputs", 0, K_ALL0, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    goto(1);
    push("first_clk_in", 0, K_INAB, 2);
    push("first_clk_in", 1, K_INAB, 2);
    push("first_clk_pwm", 0, K_PWM, 0);
    goto(10);
    push("ramp_tick1", 0, K_DUTY, 8);
    push("sat_tick1", 1, K_DUTY, 8);
    goto(20);
    push("sat_13", 1, K_DUTY, 13);
    push("ramp_tick2", 0, K_DUTY, 16);
    push("sat_settled_early", 1, K_SET, 0);
    goto(21);
    push("sat_settled", 1, K_SET, 1);
    goto(30);
    push("no_overshoot", 1, K_DUTY, 13);
    goto(320);
    push("ramp_mid", 0, K_DUTY, 256);
    goto(640);
    push("ramp_top", 0, K_DUTY, 512);
    push("settled_early", 0, K_SET, 0);
    goto(641);
    push("settled_512", 0, K_SET, 1);
    goto(4001);
    push("", 0, K_CLR, 0);
    push("", 1, K_CLR, 0);
    goto(8001);
    push("pwm_width_512", 0, K_PCNT, 2000);
    push("pwm_width_13", 1, K_PCNT, 50);
    push("fwd_in", 0, K_INAB, 2);

    goto(8010);
    target_duty[0 +: DW] = 10'd256;
    goto(8330);
    push("down_256", 0, K_DUTY, 256);
    goto(8340);
    target_dir[0] = 1'b0;
    for (int c = 8341; c <= 8400; c++) begin
      goto(c);
      push("abort_in", 0, K_INAB, 2);
      if (c == 8390) begin
        push("abort_low", 0, K_DUTY, 216);
        target_dir[0] = 1'b1;
      end
      if (c == 8399) push("abort_hold", 0, K_DUTY, 216);
      if (c == 8400) begin
        push("abort_resume", 0, K_DUTY, 224);
        target_duty[0 +: DW] = 10'd512;
      end
    end

    goto(8760);
    push("back_512", 0, K_DUTY, 512);
    goto(8770);
    target_dir[0] = 1'b0;
    goto(9090);
    push("decel_mid", 0, K_DUTY, 256);
    for (int c = 9410; c <= 9462; c++) begin
      goto(c);
      push("rev_in", 0, K_INAB, (c <= 9411) ? 2 : (c <= 9461) ? 0 : 1);
      if (c == 9410) push("decel_zero", 0, K_DUTY, 0);
      if (c == 9411) push("decel_pwm", 0, K_PWM, 1);
      if (c == 9412) push("dead_pwm", 0, K_PWM, 0);
    end
    goto(10090);
    push("rev_ramp", 0, K_DUTY, 504);
    goto(10100);
    push("rev_top", 0, K_DUTY, 512);
    goto(10101);
    push("rev_settled", 0, K_SET, 1);

    goto(10110);
    target_duty[DW +: DW] = 10'd400;
    goto(10200);
    push("ch1_ramp", 1, K_DUTY, 85);
    goto(10205);
    brake[1] = 1'b1;
    goto(10206);
    push("brake_lat1", 1, K_INAB, 2);
    goto(10207);
    push("brake_in", 1, K_INAB, 3);
    push("brake_pwm", 1, K_PWM, 0);
    push("brake_duty", 1, K_DUTY, 0);
    push("brake_settled", 1, K_SET, 0);
    push("ch0_duty", 0, K_DUTY, 512);
    push("ch0_in", 0, K_INAB, 1);
    goto(10210);
    push("brake_hold", 1, K_DUTY, 0);
    push("ch0_settled", 0, K_SET, 1);
    goto(10230);
    brake[1] = 1'b0;
    goto(10231);
    push("brake_rel_lat", 1, K_INAB, 3);
    goto(10232);
    push("brake_rel_in", 1, K_INAB, 2);
    goto(10239);
    push("brake_rel_wait", 1, K_DUTY, 0);
    goto(10240);
    push("brake_rel_ramp", 1, K_DUTY, 8);

    goto(10500);
    #2;
    rst = 1'b0;
    #1;
    push("async_reset", 0, K_ALL0, 0);
    target_duty = {10'd0, 10'd256};
    target_dir  = 2'b11;
    @(posedge clk);
    #1;
    push("reset_held", 0, K_ALL0, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    goto(320);
    push("restart_256", 0, K_DUTY, 256);
    goto(4001);
    push("", 0, K_CLR, 0);
    goto(5000);
    push("edge_hi_1000", 0, K_PWM, 1);
    target_duty[0 +: DW] = 10'd512;
    goto(5001);
    push("edge_lo_1000", 0, K_PWM, 0);
    goto(5320);
    push("mid_period_512", 0, K_DUTY, 512);
    goto(8001);
    push("period_unchanged", 0, K_PCNT, 1000);
    push("", 0, K_CLR, 0);
    goto(10000);
    push("edge_hi_2000", 0, K_PWM, 1);
    goto(10001);
    push("edge_lo_2000", 0, K_PWM, 0);
    goto(12001);
    push("next_period", 0, K_PCNT, 2000);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    if (n_chk < 12) begin
        $display("FAIL check_count: got %0d expected at least 12", n_chk);
        $fatal(1);
    end
    if (n_pass != n_chk) begin
        $display("FAIL summary: got %0d expected %0d", n_pass, n_chk);
        $fatal(1);
    end
    $display("PASS");
    $finish;
  end

endmodule
